// File: rtl/edge_event_counter.sv
// edge_event_counter
// Counts qualified single-cycle event pulses and raises a level threshold
// interrupt. The running count is handed to a consumer through a four-phase
// rd_req/rd_ack snapshot-and-clear handshake. An event that arrives on the
// same edge as a snapshot is not lost: it becomes the first count of the new
// window.
//
// Optional feature macro: EDGE_EVENT_COUNTER_OVF_EN
//   defined     : count saturates at all-ones and a sticky overflow flag
//                 records any event lost to saturation; the flag is
//                 reported through rd_ovf at snapshot time.
//   not defined : count wraps modulo 2^WIDTH and rd_ovf is always 0.
//
// Reset is synchronous and active-high.

module edge_event_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             en,
  input  logic [WIDTH-1:0] thresh,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovf,
  output logic             irq
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Count after one qualified event. Saturates when the overflow feature is
  // built in, otherwise wraps naturally through the adder carry-out.
  function automatic logic [WIDTH-1:0] count_bump(input logic [WIDTH-1:0] c);
`ifdef EDGE_EVENT_COUNTER_OVF_EN
    if (c == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return c + CNT_ONE;
    end
`else
    return c + CNT_ONE;
`endif
  endfunction

  // Threshold compare; a zero threshold disables the interrupt entirely.
  function automatic logic thresh_hit(input logic [WIDTH-1:0] c,
                                      input logic [WIDTH-1:0] t);
    if (t == CNT_ZERO) begin
      return 1'b0;
    end else begin
      return (c >= t);
    end
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic             rd_ack_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_ovf_r;
  logic             irq_r;

  logic             inc_s;
  logic             snap_s;
  logic             ovf_set_s;
  logic [WIDTH-1:0] count_next_s;
  logic             ovf_next_s;
  logic             irq_next_s;

  // Qualify events and decide whether this edge takes a snapshot.
  always_comb begin
    inc_s  = evt & en;
    snap_s = 1'b0;
    if (state_r == ST_IDLE) begin
      snap_s = rd_req;
    end else begin
      snap_s = 1'b0;
    end
  end

  // Next count and sticky overflow. A snapshot restarts the window, and the
  // same-edge event (if any) is the first count of that new window.
  always_comb begin
    count_next_s = count_r;
    ovf_next_s   = ovf_r;
    ovf_set_s    = 1'b0;
`ifdef EDGE_EVENT_COUNTER_OVF_EN
    ovf_set_s = inc_s & (count_r == CNT_MAX);
`else
    ovf_set_s = 1'b0;
`endif
    if (snap_s) begin
      count_next_s = inc_s ? CNT_ONE : CNT_ZERO;
      ovf_next_s   = 1'b0;
    end else if (inc_s) begin
      count_next_s = count_bump(count_r);
`ifdef EDGE_EVENT_COUNTER_OVF_EN
      ovf_next_s   = ovf_r | ovf_set_s;
`else
      ovf_next_s   = 1'b0;
`endif
    end else begin
      count_next_s = count_r;
      ovf_next_s   = ovf_r;
    end
  end

  // The interrupt is judged on the count that will be held after this edge.
  always_comb begin
    irq_next_s = thresh_hit(count_next_s, thresh);
  end

  // Handshake FSM, counter state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      ovf_r     <= 1'b0;
      rd_ack_r  <= 1'b0;
      rd_data_r <= CNT_ZERO;
      rd_ovf_r  <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      count_r <= count_next_s;
      ovf_r   <= ovf_next_s;
      irq_r   <= irq_next_s;
      case (state_r)
        ST_IDLE: begin
          if (rd_req) begin
            rd_data_r <= count_r;
            rd_ovf_r  <= ovf_r;
            rd_ack_r  <= 1'b1;
            state_r   <= ST_ACK;
          end else begin
            rd_ack_r  <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (rd_req) begin
            rd_ack_r <= 1'b1;
            state_r  <= ST_ACK;
          end else begin
            rd_ack_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          rd_ack_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_ack  = rd_ack_r;
  assign rd_data = rd_data_r;
  assign rd_ovf  = rd_ovf_r;
  assign irq     = irq_r;

endmodule

// File: tb/tb_edge_event_counter.sv
// Self-checking bench for edge_event_counter (WIDTH=4 so wrap/saturation is
// reached quickly). A reference model tracks the number of qualified events
// in the current snapshot window as a plain integer and derives the visible
// count from it; outputs are compared against it one step after every edge.
// Directed sequences add literal expectations.

module tb_edge_event_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         evt;
  logic         en;
  logic [W-1:0] thresh;
  logic         rd_req;
  logic         rd_ack;
  logic [W-1:0] rd_data;
  logic         rd_ovf;
  logic         irq;

  int total;
  int bad;

  // model state
  int   m_events;
  bit   m_ack;
  int   m_data;
  bit   m_ovf;
  bit   m_irq;
  bit   m_valid;

  edge_event_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .en      (en),
    .thresh  (thresh),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .rd_ovf  (rd_ovf),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // visible count for a window that has seen e qualified events
  function automatic int cnt_of(input int e);
`ifdef EDGE_EVENT_COUNTER_OVF_EN
    return (e > MAX) ? MAX : e;
`else
    return e % (MAX + 1);
`endif
  endfunction

  function automatic bit ovf_of(input int e);
`ifdef EDGE_EVENT_COUNTER_OVF_EN
    return (e > MAX);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model plus per-cycle compare.
  initial begin
    bit inc;
    m_events = 0; m_ack = 0; m_data = 0; m_ovf = 0; m_irq = 0; m_valid = 0;
    forever begin
      @(posedge clk);
      inc = evt && en;
      if (rst) begin
        m_events = 0; m_ack = 0; m_data = 0; m_ovf = 0; m_irq = 0;
        m_valid = 1;
      end else begin
        if (!m_ack && rd_req) begin
          m_data   = cnt_of(m_events);
          m_ovf    = ovf_of(m_events);
          m_events = inc ? 1 : 0;
          m_ack    = 1;
        end else begin
          m_events = m_events + (inc ? 1 : 0);
          if (m_ack && !rd_req) m_ack = 0;
        end
        m_irq = (thresh != 0) && (cnt_of(m_events) >= int'(thresh));
      end
      #1;
      if (m_valid) begin
        chk("cyc_rd_ack",  int'(rd_ack),  int'(m_ack));
        chk("cyc_rd_data", int'(rd_data), m_data);
        chk("cyc_rd_ovf",  int'(rd_ovf),  int'(m_ovf));
        chk("cyc_irq",     int'(irq),     int'(m_irq));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      evt = 1'b1; cyc(1);
      evt = 1'b0; cyc(1);
    end
  endtask

  task automatic held(input int n);
    evt = 1'b1; cyc(n);
    evt = 1'b0;
  endtask

  task automatic release_req();
    rd_req = 1'b0; cyc(2);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; evt = 1'b0; en = 1'b1; thresh = '0; rd_req = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("rst_ack",  int'(rd_ack),  0);
    chk("rst_data", int'(rd_data), 0);
    chk("rst_ovf",  int'(rd_ovf),  0);
    chk("rst_irq",  int'(irq),     0);

    // five single pulses, thresh=0
    pulses(5);
    chk("t1_ack_before", int'(rd_ack), 0);
    rd_req = 1'b1; cyc(1);
    chk("t1_ack",  int'(rd_ack),  1);
    chk("t1_data", int'(rd_data), 5);
    chk("t1_ovf",  int'(rd_ovf),  0);
    chk("t1_irq",  int'(irq),     0);
    release_req();
    chk("t1_ack_drop", int'(rd_ack), 0);

    // threshold crossing
    thresh = 4'd3;
    evt = 1'b1; cyc(2);
    chk("t2_irq_at2", int'(irq), 0);
    cyc(1); evt = 1'b0;
    chk("t2_irq_at3", int'(irq), 1);
    rd_req = 1'b1; cyc(1);
    chk("t2_data", int'(rd_data), 3);
    chk("t2_irq_clr", int'(irq), 0);
    release_req();
    thresh = 4'd0;

    // event coincident with snapshot
    held(7);
    evt = 1'b1; rd_req = 1'b1; cyc(1);
    evt = 1'b0;
    chk("t3_data", int'(rd_data), 7);
    release_req();
    rd_req = 1'b1; cyc(1);
    chk("t3_data2", int'(rd_data), 1);
    release_req();

    // overflow with 17 events
    held(17);
    rd_req = 1'b1; cyc(1);
`ifdef EDGE_EVENT_COUNTER_OVF_EN
    chk("t4_data", int'(rd_data), 15);
    chk("t4_ovf",  int'(rd_ovf),  1);
`else
    chk("t4_data", int'(rd_data), 1);
    chk("t4_ovf",  int'(rd_ovf),  0);
`endif
    release_req();
    rd_req = 1'b1; cyc(1);
    chk("t4_ovf2",  int'(rd_ovf),  0);
    chk("t4_data2", int'(rd_data), 0);
    release_req();

    // en=0 ignores events; long request gives one snapshot only
    en = 1'b0; pulses(4); en = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      evt = (i % 2 == 0);
      cyc(1);
      chk("t5_ack_hold",  int'(rd_ack),  1);
      chk("t5_data_hold", int'(rd_data), 0);
    end
    evt = 1'b0;
    release_req();

    // reset mid-handshake
    thresh = 4'd5;
    rd_req = 1'b1; cyc(1);
    held(9);
    chk("t6_irq_pre", int'(irq), 1);
    chk("t6_ack_pre", int'(rd_ack), 1);
    rst = 1'b1; cyc(1);
    chk("t6_ack",  int'(rd_ack),  0);
    chk("t6_data", int'(rd_data), 0);
    chk("t6_irq",  int'(irq),     0);
    rst = 1'b0; cyc(1);
    chk("t6_reack", int'(rd_ack),  1);
    chk("t6_data2", int'(rd_data), 0);
    release_req();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      evt = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) thresh = W'($urandom_range(0, MAX));
      if ($urandom_range(0, 5) == 0) rd_req = ~rd_req;
      rst = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 1'b0; evt = 1'b0; rd_req = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
